// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the byte-wide RAM port controller:
//   - bus width typedefs (address, byte, instruction)
//   - LSB access size encodings
//   - controller state encoding
//   - requester identifiers used by the round-robin arbiter
//   - default value of addr[17:16] that marks the IO window
//   - small decode helpers used by mem_ctrl
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef logic [31:0] addr_bus_t;
  typedef logic [7:0]  byte_bus_t;
  typedef logic [31:0] inst_bus_t;

  // LSB access size encodings (3 is illegal and decodes as a word).
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // addr[17:16] value that selects the IO space.
  localparam logic [1:0] IO_SEL_DEFAULT = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  // Requester identity, used both for the current owner and last grant.
  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  // Number of RAM byte cycles for an LSB access size.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      SIZE_W:  n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // True when the address window bits select IO space.
  function automatic logic is_io_sel(input logic [1:0] win_bits,
                                     input logic [1:0] io_sel);
    return (win_bits == io_sel);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Arbiter and byte sequencer for the single byte-wide RAM port shared by the
// instruction fetch unit and the load/store buffer.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (0 freezes all state)
//   clear            pipeline flush: aborts reads, blocks acceptance in IDLE
//   io_buffer_full   stalls IO-space writes while high
//   if_req/if_addr   fetch 4-byte read request; if_done/if_inst result
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata  LSB request; ls_done/ls_rdata
//   mem_din/mem_dout/mem_a/mem_wr           RAM port (read data one cycle
//                                           after its address)
//
// Timing: a read of n bytes drives addresses in the n cycles after the accept
// edge and reports done n+2 cycles after accept. A write of n bytes drives one
// byte per cycle and reports done n+1 cycles after accept when not stalled.
// -----------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_SEL = IO_SEL_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  mc_state_e  state_r,      state_nxt_s;
  grant_e     owner_r,      owner_nxt_s;
  grant_e     last_grant_r, last_grant_nxt_s;
  addr_bus_t  addr_r,       addr_nxt_s;
  logic [2:0] n_r,          n_nxt_s;
  // READ: cycles elapsed since accept. WRITE: index of the byte on the bus.
  logic [2:0] cnt_r,        cnt_nxt_s;
  logic [31:0] wdata_r,     wdata_nxt_s;
  logic [31:0] asm_r,       asm_nxt_s;
  addr_bus_t  mem_a_r,      mem_a_nxt_s;
  byte_bus_t  mem_dout_r,   mem_dout_nxt_s;
  logic       mem_wr_r,     mem_wr_nxt_s;
  logic       if_done_r,    if_done_nxt_s;
  inst_bus_t  if_inst_r,    if_inst_nxt_s;
  logic       ls_done_r,    ls_done_nxt_s;
  logic [31:0] ls_rdata_r,  ls_rdata_nxt_s;

  logic [31:0] asm_s;
  logic [1:0]  rd_idx_s;
  logic [1:0]  wr_idx_s;
  logic        io_stall_s;
  logic        accept_s;
  logic        pick_ls_s;

  // The byte arriving at the end of read cycle cnt belongs to address cnt-1;
  // for cnt = 4 the 2-bit wrap gives index 3 as required.
  always_comb begin
    rd_idx_s = cnt_r[1:0] - 2'd1;
    asm_s    = asm_r;
    asm_s[{rd_idx_s, 3'b000} +: 8] = mem_din;
  end

  // Write-side strobes and arbitration decode.
  always_comb begin
    wr_idx_s   = cnt_r[1:0] + 2'd1;
    io_stall_s = (state_r == MC_WRITE) &&
                 is_io_sel(addr_r[17:16], IO_SEL) && io_buffer_full;
    // A done pulse still high means the requester has not yet dropped req.
    accept_s   = !clear && !if_done_r && !ls_done_r && (if_req || ls_req);
    // Fetch wins a tie unless it was the last one served.
    pick_ls_s  = ls_req && (!if_req || (last_grant_r == GRANT_IF));
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    last_grant_nxt_s = last_grant_r;
    addr_nxt_s       = addr_r;
    n_nxt_s          = n_r;
    cnt_nxt_s        = cnt_r;
    wdata_nxt_s      = wdata_r;
    asm_nxt_s        = asm_r;
    mem_a_nxt_s      = mem_a_r;
    mem_dout_nxt_s   = mem_dout_r;
    mem_wr_nxt_s     = mem_wr_r;
    if_done_nxt_s    = 1'b0;
    if_inst_nxt_s    = if_inst_r;
    ls_done_nxt_s    = 1'b0;
    ls_rdata_nxt_s   = ls_rdata_r;

    case (state_r)
      MC_IDLE: begin
        mem_a_nxt_s    = 32'd0;
        mem_dout_nxt_s = 8'd0;
        mem_wr_nxt_s   = 1'b0;
        cnt_nxt_s      = 3'd0;
        asm_nxt_s      = 32'd0;
        if (accept_s) begin
          if (pick_ls_s) begin
            owner_nxt_s      = GRANT_LS;
            last_grant_nxt_s = GRANT_LS;
            addr_nxt_s       = ls_addr;
            n_nxt_s          = size_to_bytes(ls_size);
            wdata_nxt_s      = ls_wdata;
            mem_a_nxt_s      = ls_addr;
            if (ls_we) begin
              state_nxt_s    = MC_WRITE;
              mem_wr_nxt_s   = 1'b1;
              mem_dout_nxt_s = ls_wdata[7:0];
            end else begin
              state_nxt_s    = MC_READ;
            end
          end else begin
            owner_nxt_s      = GRANT_IF;
            last_grant_nxt_s = GRANT_IF;
            addr_nxt_s       = if_addr;
            n_nxt_s          = 3'd4;
            wdata_nxt_s      = 32'd0;
            mem_a_nxt_s      = if_addr;
            state_nxt_s      = MC_READ;
          end
        end else begin
          state_nxt_s = MC_IDLE;
        end
      end

      MC_READ: begin
        if (clear) begin
          // Speculative read: drop it and everything collected so far.
          state_nxt_s = MC_IDLE;
          mem_a_nxt_s = 32'd0;
          cnt_nxt_s   = 3'd0;
          asm_nxt_s   = 32'd0;
        end else if (cnt_r == n_r) begin
          state_nxt_s = MC_IDLE;
          mem_a_nxt_s = 32'd0;
          cnt_nxt_s   = 3'd0;
          asm_nxt_s   = asm_s;
          if (owner_r == GRANT_IF) begin
            if_done_nxt_s = 1'b1;
            if_inst_nxt_s = asm_s;
          end else begin
            ls_done_nxt_s  = 1'b1;
            ls_rdata_nxt_s = asm_s;
          end
        end else begin
          cnt_nxt_s = cnt_r + 3'd1;
          if (cnt_r != 3'd0) begin
            asm_nxt_s = asm_s;
          end else begin
            asm_nxt_s = asm_r;
          end
          // Keep issuing addresses until all n have gone out, then park at 0
          // while the final byte comes back.
          if ((cnt_r + 3'd1) < n_r) begin
            mem_a_nxt_s = addr_r + {29'd0, cnt_r} + 32'd1;
          end else begin
            mem_a_nxt_s = 32'd0;
          end
        end
      end

      MC_WRITE: begin
        // Stores are committed, so clear has no effect here.
        if (io_stall_s) begin
          state_nxt_s = MC_WRITE;
        end else if (cnt_r == (n_r - 3'd1)) begin
          state_nxt_s    = MC_IDLE;
          cnt_nxt_s      = 3'd0;
          mem_wr_nxt_s   = 1'b0;
          mem_a_nxt_s    = 32'd0;
          mem_dout_nxt_s = 8'd0;
          ls_done_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s      = cnt_r + 3'd1;
          mem_a_nxt_s    = addr_r + {29'd0, cnt_r} + 32'd1;
          mem_dout_nxt_s = wdata_r[{wr_idx_s, 3'b000} +: 8];
        end
      end

      default: begin
        state_nxt_s    = MC_IDLE;
        cnt_nxt_s      = 3'd0;
        mem_a_nxt_s    = 32'd0;
        mem_dout_nxt_s = 8'd0;
        mem_wr_nxt_s   = 1'b0;
      end
    endcase
  end

  // State and output registers; rdy_in low freezes everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= MC_IDLE;
      owner_r      <= GRANT_IF;
      last_grant_r <= GRANT_LS;
      addr_r       <= 32'd0;
      n_r          <= 3'd0;
      cnt_r        <= 3'd0;
      wdata_r      <= 32'd0;
      asm_r        <= 32'd0;
      mem_a_r      <= 32'd0;
      mem_dout_r   <= 8'd0;
      mem_wr_r     <= 1'b0;
      if_done_r    <= 1'b0;
      if_inst_r    <= 32'd0;
      ls_done_r    <= 1'b0;
      ls_rdata_r   <= 32'd0;
    end else if (rdy_in) begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      addr_r       <= addr_nxt_s;
      n_r          <= n_nxt_s;
      cnt_r        <= cnt_nxt_s;
      wdata_r      <= wdata_nxt_s;
      asm_r        <= asm_nxt_s;
      mem_a_r      <= mem_a_nxt_s;
      mem_dout_r   <= mem_dout_nxt_s;
      mem_wr_r     <= mem_wr_nxt_s;
      if_done_r    <= if_done_nxt_s;
      if_inst_r    <= if_inst_nxt_s;
      ls_done_r    <= ls_done_nxt_s;
      ls_rdata_r   <= ls_rdata_nxt_s;
    end
  end

  // The IO stall gates the write strobe in the same cycle the buffer reports
  // full, so no byte is ever pushed into a full IO sink.
  assign mem_wr   = mem_wr_r & ~io_stall_s;
  assign mem_a    = mem_a_r;
  assign mem_dout = mem_dout_r;
  assign if_done  = if_done_r;
  assign if_inst  = if_inst_r;
  assign ls_done  = ls_done_r;
  assign ls_rdata = ls_rdata_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl. A behavioural byte RAM (one-cycle read latency,
// frozen with rdy_in) feeds mem_din; each step checks the cycle-exact outputs.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        io_buffer_full;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_inst;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int n_cmp;
  int n_err;

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_inst        (if_inst),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_size        (ls_size),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Read-only RAM image for the addresses the bench reads.
  function automatic logic [7:0] ram_read(input logic [31:0] a);
    logic [7:0] d;
    case (a)
      32'h0:   d = 8'h13;
      32'h1:   d = 8'h05;
      32'h2:   d = 8'h10;
      32'h3:   d = 8'h00;
      32'h5:   d = 8'hF0;
      32'h6:   d = 8'h00;
      32'h7:   d = 8'h5A;
      32'h8:   d = 8'h11;
      32'h9:   d = 8'h22;
      32'hA:   d = 8'h33;
      32'hB:   d = 8'h44;
      default: d = 8'h00;
    endcase
    return d;
  endfunction

  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= ram_read(mem_a);
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
    tick(); tick();
    check("rst_mem_a",    mem_a,    32'd0);
    check("rst_mem_wr",   {31'd0, mem_wr}, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_if_done",  {31'd0, if_done}, 32'd0);
    check("rst_ls_done",  {31'd0, ls_done}, 32'd0);
    check("rst_if_inst",  if_inst,  32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    rst_in = 1'b1;

    // Fetch of 0x0 and a byte load of 0x7 requested together: fetch first.
    if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h7;
    tick(); check("f0_a_c1", mem_a, 32'h0); check("f0_wr_c1", {31'd0, mem_wr}, 32'd0);
    tick(); check("f0_a_c2", mem_a, 32'h1);
    tick(); check("f0_a_c3", mem_a, 32'h2);
    tick(); check("f0_a_c4", mem_a, 32'h3);
    tick(); check("f0_a_c5", mem_a, 32'h0); check("f0_done_c5", {31'd0, if_done}, 32'd0);
    tick(); check("f0_done_c6", {31'd0, if_done}, 32'd1);
            check("f0_inst", if_inst, 32'h00100513);
            check("f0_lsdone_c6", {31'd0, ls_done}, 32'd0);
    if_req = 1'b0;
    tick(); check("f0_pulse", {31'd0, if_done}, 32'd0);
            check("f0_inst_hold", if_inst, 32'h00100513);
            check("arb_idle_on_done", mem_a, 32'h0);
    tick(); check("ls_second_a", mem_a, 32'h7);
    tick(); check("ls_b_a_c2", mem_a, 32'h0);
    tick(); check("ls_b_done", {31'd0, ls_done}, 32'd1);
            check("ls_b_rdata", ls_rdata, 32'h0000005A);

    // Both requesting again: grants alternate (fetch, then LSB, then fetch).
    if_req = 1'b1; if_addr = 32'h8; ls_size = 2'd1; ls_addr = 32'h6;
    tick(); check("alt1_lsdone_pulse", {31'd0, ls_done}, 32'd0);
            check("alt1_idle", mem_a, 32'h0);
    tick(); check("alt1_fetch_wins", mem_a, 32'h8);
    tick(); tick(); tick(); tick();
    tick(); check("alt1_if_done", {31'd0, if_done}, 32'd1);
            check("alt1_inst", if_inst, 32'h44332211);
    if_addr = 32'hC;
    tick(); check("alt2_idle", mem_a, 32'h0);
    tick(); check("alt2_ls_wins", mem_a, 32'h6);
    tick(); check("alt2_a1", mem_a, 32'h7);
    tick(); check("alt2_a_park", mem_a, 32'h0);
    tick(); check("alt2_ls_done", {31'd0, ls_done}, 32'd1);
            check("alt2_rdata", ls_rdata, 32'h00005A00);
    ls_req = 1'b0;
    tick();
    tick(); check("alt3_fetch", mem_a, 32'hC);
    tick(); tick(); tick(); tick();
    tick(); check("alt3_if_done", {31'd0, if_done}, 32'd1);
            check("alt3_inst", if_inst, 32'h0);
    if_req = 1'b0;
    tick();

    // Half store 0xBEEF to 0x1000.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h1000; ls_wdata = 32'h0000BEEF;
    tick(); check("sh_wr_c1", {31'd0, mem_wr}, 32'd1);
            check("sh_a_c1", mem_a, 32'h1000);
            check("sh_d_c1", {24'd0, mem_dout}, 32'hEF);
    tick(); check("sh_wr_c2", {31'd0, mem_wr}, 32'd1);
            check("sh_a_c2", mem_a, 32'h1001);
            check("sh_d_c2", {24'd0, mem_dout}, 32'hBE);
            check("sh_nodone_c2", {31'd0, ls_done}, 32'd0);
    tick(); check("sh_done_c3", {31'd0, ls_done}, 32'd1);
            check("sh_wr_c3", {31'd0, mem_wr}, 32'd0);
    ls_req = 1'b0;
    tick();

    // IO byte store with the IO buffer full for three cycles.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h00030000; ls_wdata = 32'h00000077;
    io_buffer_full = 1'b1;
    tick(); check("io_stall_c1", {31'd0, mem_wr}, 32'd0);
            check("io_a_c1", mem_a, 32'h00030000);
    tick(); check("io_stall_c2", {31'd0, mem_wr}, 32'd0);
    tick(); check("io_stall_c3", {31'd0, mem_wr}, 32'd0);
            check("io_nodone_c3", {31'd0, ls_done}, 32'd0);
    tick(); io_buffer_full = 1'b0; #1;
            check("io_wr_c4", {31'd0, mem_wr}, 32'd1);
            check("io_a_c4", mem_a, 32'h00030000);
            check("io_d_c4", {24'd0, mem_dout}, 32'h77);
    tick(); check("io_done_c5", {31'd0, ls_done}, 32'd1);
            check("io_wr_c5", {31'd0, mem_wr}, 32'd0);
    ls_req = 1'b0;
    tick();

    // clear during a fetch read: abort, then the held request is re-accepted.
    if_req = 1'b1; if_addr = 32'h8;
    tick(); check("clr_a_c1", mem_a, 32'h8);
    tick(); check("clr_a_c2", mem_a, 32'h9);
    tick(); check("clr_a_c3", mem_a, 32'hA);
    clear = 1'b1;
    tick(); clear = 1'b0;
            check("clr_idle_a", mem_a, 32'h0);
            check("clr_no_done", {31'd0, if_done}, 32'd0);
    tick(); check("clr_reaccept", mem_a, 32'h8);
    tick(); tick(); tick(); tick();
            check("clr_no_early_done", {31'd0, if_done}, 32'd0);
    tick(); check("clr_done", {31'd0, if_done}, 32'd1);
            check("clr_inst", if_inst, 32'h44332211);
    if_req = 1'b0;
    tick();

    // clear during a word store has no effect.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h2000; ls_wdata = 32'hDDCCBBAA;
    tick(); check("sw_a_c1", mem_a, 32'h2000); check("sw_d_c1", {24'd0, mem_dout}, 32'hAA);
    tick(); check("sw_a_c2", mem_a, 32'h2001); check("sw_d_c2", {24'd0, mem_dout}, 32'hBB);
    clear = 1'b1;
    tick(); clear = 1'b0;
            check("sw_a_c3", mem_a, 32'h2002); check("sw_d_c3", {24'd0, mem_dout}, 32'hCC);
            check("sw_wr_c3", {31'd0, mem_wr}, 32'd1);
    tick(); check("sw_a_c4", mem_a, 32'h2003); check("sw_d_c4", {24'd0, mem_dout}, 32'hDD);
    tick(); check("sw_done", {31'd0, ls_done}, 32'd1);
            check("sw_wr_c5", {31'd0, mem_wr}, 32'd0);
    ls_req = 1'b0;
    tick();

    // rdy_in low for two cycles freezes a fetch in progress.
    if_req = 1'b1; if_addr = 32'h0;
    tick(); check("rdy_a_c1", mem_a, 32'h0);
    tick(); check("rdy_a_c2", mem_a, 32'h1);
    rdy_in = 1'b0;
    tick(); check("rdy_hold1", mem_a, 32'h1);
    tick(); check("rdy_hold2", mem_a, 32'h1);
    rdy_in = 1'b1;
    tick(); check("rdy_a_c3", mem_a, 32'h2);
    tick(); check("rdy_a_c4", mem_a, 32'h3);
    tick(); check("rdy_nodone", {31'd0, if_done}, 32'd0);
    tick(); check("rdy_done", {31'd0, if_done}, 32'd1);
            check("rdy_inst", if_inst, 32'h00100513);
    if_req = 1'b0;
    tick();

    // Asynchronous reset in the middle of a word load.
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h0;
    tick(); check("rl_a_c1", mem_a, 32'h0);
    tick(); check("rl_a_c2", mem_a, 32'h1);
    rst_in = 1'b0;
    #1;
    check("rl_async_a", mem_a, 32'h0);
    check("rl_async_inst", if_inst, 32'h0);
    check("rl_async_rdata", ls_rdata, 32'h0);
    ls_req = 1'b0;
    tick();
    rst_in = 1'b1;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h5;
    tick(); check("rl_a5", mem_a, 32'h5);
            check("rl_no_stale_done", {31'd0, ls_done}, 32'd0);
    tick(); check("rl_park", mem_a, 32'h0);
    tick(); check("rl_done_c3", {31'd0, ls_done}, 32'd1);
            check("rl_rdata", ls_rdata, 32'h000000F0);
    ls_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
Arbiter and sequencer for the single byte-wide RAM port, which is shared between the instruction fetch unit and the load/store buffer (LSB). Grants one requester at a time with round-robin fairness. Breaks each 1/2/4-byte access into per-byte RAM cycles, assembles read data little-endian, and pulses done. Also aborts speculative reads on pipeline flush and stalls IO writes while the IO buffer is full.

Parameters:
IO_SEL, 2'b11, value of addr[17:16] that marks an IO address

Ports:
clk_in  in  1  clock
rst_in  in  1  asynchronous active-low reset (0 = reset)
rdy_in  in  1  global ready; 0 freezes all state
clear  in  1  pipeline flush (ROB change_pc)
io_buffer_full  in  1  IO write sink cannot accept
if_req  in  1  fetch requests 4-byte read
if_addr  in  32  fetch address
if_done  out  1  one-cycle pulse: if_inst valid
if_inst  out  32  assembled instruction
ls_req  in  1  LSB request
ls_we  in  1  1 = store, 0 = load
ls_size  in  2  0 = byte, 1 = half, 2 = word (3 illegal, treated as word)
ls_addr  in  32  LSB address
ls_wdata  in  32  store data, low bytes used
ls_done  out  1  one-cycle pulse: access complete
ls_rdata  out  32  load data, zero-extended (LSB sign-extends)
mem_din  in  8  RAM read byte, valid the cycle after its address
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write

Behaviour:
- Reset (rst_in = 0, asynchronous): state IDLE; all outputs 0; last_grant = LSB, so fetch wins the first tie.
- rdy_in = 0: no register changes. Outputs hold their values.
- States:
  - IDLE: mem_wr = 0 and mem_a = 0.
  - IDLE also ignores requests in any cycle where if_done or ls_done is high. The requester must drop req on seeing done.
- Arbitration, on an IDLE edge with clear = 0:
  - One requester: grant it.
  - Both requesting: grant the one not in last_grant.
  - Latch addr, byte count n (fetch = 4; LSB = 1/2/4), wdata and we.
  - Go to READ or WRITE.
- READ, byte count n:
  - Cycles C1..Cn after the accept edge E0 drive mem_a = addr + k, k = 0..n-1.
  - Byte k is taken from mem_din at edge E(k+2).
  - At E(n+1): assemble the result, with byte 0 in bits 7:0. Set the requester's done, write its data output, and return to IDLE.
  - Done is visible in cycle C(n+2). A word read is visible 6 cycles after accept.
- WRITE, byte count n:
  - Each cycle drives mem_wr = 1, mem_a = addr + k and mem_dout = wdata[8k+7:8k].
  - k advances on each edge. After the last byte: ls_done = 1, mem_wr = 0, return to IDLE.
  - Done is visible in C(n+1) when there is no stall.
- IO stall: while in WRITE with addr[17:16] == IO_SEL and io_buffer_full = 1:
  - Drive mem_wr = 0 and hold k.
  - Resume with the same byte once io_buffer_full falls.
- clear = 1:
  - Aborts any READ (fetch or LSB load) at that edge: state goes to IDLE, no done, collected bytes discarded.
  - An in-flight WRITE is never aborted, because stores are committed.
  - clear in IDLE blocks acceptance on that edge.
- Address arithmetic is 32-bit wrap. Unaligned accesses are legal.
- done pulses last exactly one cycle. if_inst and ls_rdata hold their value until the next done.
- Reset mid-access: the access is abandoned immediately and no done is issued.

Decomposition:
- Add to constant.v:
  - AddrBus, ByteBus, InstBus (already present).
  - Size encodings SIZE_B, SIZE_H, SIZE_W.
  - State encodings MC_IDLE, MC_READ, MC_WRITE.
  - IO_SEL.
- No sub-module. A single always block with a byte counter and an assembly register fits in about 200 lines.

Test Plan:
1. Fetch 0x0, RAM[0..3] = 13 05 10 00 → if_done in C6 with if_inst = 0x00100513; mem_a = 0,1,2,3 in C1..C4.
2. if_req and ls_req rise together after reset → fetch is granted first, then the LSB. Repeat with both asserted → grants alternate.
3. Store half, ls_addr = 0x1000, ls_wdata = 0x0000BEEF → mem_wr = 1 with (0x1000, EF) then (0x1001, BE); ls_done in C3.
4. Store byte to 0x30000 with io_buffer_full = 1 for 3 cycles → mem_wr stays 0 for 3 cycles, then one write of the byte; ls_done follows.
5. clear in C3 of a fetch read → no if_done, IDLE next cycle, a new if_req is accepted; clear during a word store → all 4 writes complete and ls_done fires.
6. rst_in low mid-load (async, between edges) → all outputs 0 immediately; after release, a load byte from 0x5 with RAM[5] = 0xF0 gives ls_rdata = 0x000000F0 in C3.
